// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: variable-latency data-memory access, upstream stall, branch/jump
// redirect, MEM/WB register and sticky data-memory timeout error.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_mem_ctrl_reg_write,
    input  logic         ex_mem_ctrl_mem_to_reg,
    input  logic         ex_mem_ctrl_mem_read,
    input  logic         ex_mem_ctrl_mem_write,
    input  logic         ex_mem_ctrl_branch,
    input  logic         ex_mem_ctrl_jump,
    input  logic [31:0]  ex_mem_alu_out,
    input  logic [31:0]  ex_mem_reg_b_data,
    input  logic [4:0]   ex_mem_write_reg_dst,
    input  logic         ex_mem_alu_zero,
    input  logic [31:0]  ex_mem_pc_branch,
    input  logic [31:0]  ex_mem_pc_jump,
    mem_stage_if.master  dmem,
    output logic         stall_mem,
    output logic         pc_redirect,
    output logic [31:0]  pc_target,
    output logic         mem_err,
    output logic         mem_wb_reg_write,
    output logic [4:0]   mem_wb_write_reg_dst,
    output logic [31:0]  mem_wb_data,
    output logic [31:0]  mem_wb_alu_out,
    output logic [31:0]  mem_wb_mem_rdata,
    output logic         mem_wb_ctrl_mem_to_reg
);

    typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_next;
    logic        w_mem_op;
    logic        w_is_load;
    logic        w_req;
    logic        w_stall;
    logic        w_err;

    logic        r_reg_write;
    logic [4:0]  r_write_reg_dst;
    logic [31:0] r_data;
    logic [31:0] r_alu_out;
    logic [31:0] r_mem_rdata;
    logic        r_mem_to_reg;

    // A set write bit wins, so read+write is a store.
    assign w_mem_op  = ex_mem_ctrl_mem_read | ex_mem_ctrl_mem_write;
    assign w_is_load = ex_mem_ctrl_mem_read & ~ex_mem_ctrl_mem_write;

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = ex_mem_ctrl_mem_write;
    assign dmem.dmem_addr  = {ex_mem_alu_out[31:2], 2'b00};
    assign dmem.dmem_wdata = ex_mem_reg_b_data;

    assign stall_mem = w_stall;
    assign mem_err   = w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_req           = 1'b0;
        w_stall         = 1'b0;
        w_err           = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_req = w_mem_op;
                if (w_mem_op && !dmem.dmem_ready) begin
                    w_stall         = 1'b1;
                    w_state_next    = StWait;
                    w_wait_cnt_next = 8'd0;
                end
            end
            StWait: begin
                w_req = 1'b1;
                if (dmem.dmem_ready) begin
                    w_state_next = StIdle;
                end else if (r_wait_cnt == LastCnt) begin
                    w_stall      = 1'b1;
                    w_state_next = StErr;
                end else begin
                    w_stall         = 1'b1;
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end
            StErr: begin
                w_stall = 1'b1;
                w_err   = 1'b1;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        if (!w_stall) begin
            if (ex_mem_ctrl_jump) begin
                pc_redirect = 1'b1;
                pc_target   = ex_mem_pc_jump;
            end else if (ex_mem_ctrl_branch && ex_mem_alu_zero) begin
                pc_redirect = 1'b1;
                pc_target   = ex_mem_pc_branch;
            end
        end
    end

    // A stalled cycle becomes a bubble; payload fields hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write     <= 1'b0;
            r_write_reg_dst <= 5'd0;
            r_data          <= 32'd0;
            r_alu_out       <= 32'd0;
            r_mem_rdata     <= 32'd0;
            r_mem_to_reg    <= 1'b0;
        end else if (w_stall) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_reg_write     <= ex_mem_ctrl_reg_write;
            r_write_reg_dst <= ex_mem_write_reg_dst;
            r_alu_out       <= ex_mem_alu_out;
            r_mem_rdata     <= w_is_load ? dmem.dmem_rdata : 32'd0;
            r_mem_to_reg    <= ex_mem_ctrl_mem_to_reg;
            r_data          <= ex_mem_ctrl_mem_to_reg ? dmem.dmem_rdata : ex_mem_alu_out;
        end
    end

    assign mem_wb_reg_write       = r_reg_write;
    assign mem_wb_write_reg_dst   = r_write_reg_dst;
    assign mem_wb_data            = r_data;
    assign mem_wb_alu_out         = r_alu_out;
    assign mem_wb_mem_rdata       = r_mem_rdata;
    assign mem_wb_ctrl_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard queue of MEM/WB captures checked by a monitor,
// plus inline checks of the combinational request/stall/redirect outputs.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write, mem_to_reg, mem_read, mem_write, branch, jump, alu_zero;
    logic [31:0] alu_out, reg_b, pc_branch, pc_jump;
    logic [4:0]  rd;
    logic        stall_mem, pc_redirect, mem_err;
    logic [31:0] pc_target;
    logic        wb_rw, wb_m2r;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_alu, wb_rdata;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
    } wb_t;

    wb_t sb_q[$];
    logic track;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ex_mem_ctrl_reg_write  (reg_write),
        .ex_mem_ctrl_mem_to_reg (mem_to_reg),
        .ex_mem_ctrl_mem_read   (mem_read),
        .ex_mem_ctrl_mem_write  (mem_write),
        .ex_mem_ctrl_branch     (branch),
        .ex_mem_ctrl_jump       (jump),
        .ex_mem_alu_out         (alu_out),
        .ex_mem_reg_b_data      (reg_b),
        .ex_mem_write_reg_dst   (rd),
        .ex_mem_alu_zero        (alu_zero),
        .ex_mem_pc_branch       (pc_branch),
        .ex_mem_pc_jump         (pc_jump),
        .dmem                   (bus.master),
        .stall_mem              (stall_mem),
        .pc_redirect            (pc_redirect),
        .pc_target              (pc_target),
        .mem_err                (mem_err),
        .mem_wb_reg_write       (wb_rw),
        .mem_wb_write_reg_dst   (wb_rd),
        .mem_wb_data            (wb_data),
        .mem_wb_alu_out         (wb_alu),
        .mem_wb_mem_rdata       (wb_rdata),
        .mem_wb_ctrl_mem_to_reg (wb_m2r)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        {reg_write, mem_to_reg, mem_read, mem_write, branch, jump, alu_zero} = '0;
        alu_out   = '0;
        reg_b     = '0;
        pc_branch = '0;
        pc_jump   = '0;
        rd        = '0;
        track     = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
    endtask

    task automatic expect_wb(input logic rw_e, input logic [4:0] rd_e, input logic [31:0] data_e,
                             input logic [31:0] alu_e, input logic [31:0] rdata_e,
                             input logic m2r_e);
        wb_t e;
        e.rw = rw_e; e.rd = rd_e; e.data = data_e; e.alu = alu_e; e.rdata = rdata_e; e.m2r = m2r_e;
        sb_q.push_back(e);
        track = 1'b1;
    endtask

    // A tracked instruction seen unstalled at one negedge lands in MEM/WB by the next one.
    initial begin : monitor
        logic pending;
        wb_t  e;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_capture", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("wb_reg_write", 32'(wb_rw), 32'(e.rw));
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_data", wb_data, e.data);
                    check("wb_alu_out", wb_alu, e.alu);
                    check("wb_mem_rdata", wb_rdata, e.rdata);
                    check("wb_mem_to_reg", 32'(wb_m2r), 32'(e.m2r));
                end
            end
            pending = !rst && !stall_mem && track;
        end
    end

    initial begin : stimulus
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_reg_write", 32'(wb_rw), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_req", 32'(bus.dmem_req), 32'd0);
        check("rst_stall", 32'(stall_mem), 32'd0);
        step();
        rst = 1'b0;

        // Zero-wait load
        mem_read = 1; mem_to_reg = 1; reg_write = 1; alu_out = 32'h0000_1004; rd = 5;
        bus.dmem_ready = 1; bus.dmem_rdata = 32'hDEAD_BEEF;
        expect_wb(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("ld_req", 32'(bus.dmem_req), 32'd1);
        check("ld_we", 32'(bus.dmem_we), 32'd0);
        check("ld_addr", bus.dmem_addr, 32'h0000_1004);
        check("ld_stall", 32'(stall_mem), 32'd0);

        // ALU op ahead of the store, so MEM/WB holds visible data during the stall
        step();
        drive_idle();
        reg_write = 1; alu_out = 32'h55; rd = 3;
        expect_wb(1'b1, 5'd3, 32'h55, 32'h55, 32'h0, 1'b0);
        @(negedge clk);
        check("alu_req", 32'(bus.dmem_req), 32'd0);

        // Three-wait store, ready on the 4th request cycle
        step();
        drive_idle();
        mem_write = 1; alu_out = 32'h0000_2007; reg_b = 32'h1234_5678;
        expect_wb(1'b0, 5'd0, 32'h0000_2007, 32'h0000_2007, 32'h0, 1'b0);
        @(negedge clk);
        check("st_addr", bus.dmem_addr, 32'h0000_2004);
        check("st_wdata", bus.dmem_wdata, 32'h1234_5678);
        check("st_we", 32'(bus.dmem_we), 32'd1);
        check("st_stall_c1", 32'(stall_mem), 32'd1);
        for (int i = 2; i <= 3; i++) begin
            step();
            @(negedge clk);
            check("st_stall_wait", 32'(stall_mem), 32'd1);
            check("st_req_wait", 32'(bus.dmem_req), 32'd1);
            check("st_bubble", 32'(wb_rw), 32'd0);
        end
        step();
        bus.dmem_ready = 1; bus.dmem_rdata = 32'hAAAA_AAAA;
        @(negedge clk);
        check("st_stall_done", 32'(stall_mem), 32'd0);
        check("st_no_err", 32'(mem_err), 32'd0);

        // Branch taken / not taken, then jump priority
        step();
        drive_idle();
        branch = 1; alu_zero = 1; pc_branch = 32'h0040_0020; pc_jump = 32'h0040_1000;
        @(negedge clk);
        check("br_redirect", 32'(pc_redirect), 32'd1);
        check("br_target", pc_target, 32'h0040_0020);
        step();
        alu_zero = 0;
        @(negedge clk);
        check("br_nt_redirect", 32'(pc_redirect), 32'd0);
        check("br_nt_target", pc_target, 32'd0);
        step();
        alu_zero = 1; jump = 1;
        @(negedge clk);
        check("jmp_redirect", 32'(pc_redirect), 32'd1);
        check("jmp_target", pc_target, 32'h0040_1000);

        // Reset in the 2nd wait cycle of a store
        step();
        drive_idle();
        reg_write = 1; alu_out = 32'h99; rd = 9;
        expect_wb(1'b1, 5'd9, 32'h99, 32'h99, 32'h0, 1'b0);
        step();
        drive_idle();
        mem_write = 1; alu_out = 32'h0000_3000; reg_b = 32'h1;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rstw_wb_reg_write", 32'(wb_rw), 32'd0);
        check("rstw_wb_rd", 32'(wb_rd), 32'd0);
        check("rstw_wb_data", wb_data, 32'd0);
        check("rstw_wb_alu", wb_alu, 32'd0);
        check("rstw_mem_err", 32'(mem_err), 32'd0);
        check("rstw_req", 32'(bus.dmem_req), 32'd1);
        step();
        rst = 1'b0;
        drive_idle();
        reg_write = 1; alu_out = 32'd7; rd = 7;
        expect_wb(1'b1, 5'd7, 32'd7, 32'd7, 32'd0, 1'b0);

        // Timeout with TIMEOUT=4: five request cycles, then sticky error
        step();
        drive_idle();
        mem_read = 1; alu_out = 32'h0000_4000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("to_req", 32'(bus.dmem_req), 32'd1);
            check("to_err_early", 32'(mem_err), 32'd0);
            step();
        end
        @(negedge clk);
        check("to_err", 32'(mem_err), 32'd1);
        check("to_req_off", 32'(bus.dmem_req), 32'd0);
        check("to_stall", 32'(stall_mem), 32'd1);
        step();
        bus.dmem_ready = 1; jump = 1; pc_jump = 32'h0040_1000;
        repeat (2) begin
            @(negedge clk);
            check("late_err", 32'(mem_err), 32'd1);
            check("late_stall", 32'(stall_mem), 32'd1);
            check("late_req", 32'(bus.dmem_req), 32'd0);
            check("late_redirect", 32'(pc_redirect), 32'd0);
            check("late_bubble", 32'(wb_rw), 32'd0);
            step();
        end

        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
